// File: rtl/fb_rect_fill_if.sv
// Command handshake and framebuffer write port of the rectangle-fill engine.
// The master side issues commands and owns the RAM stall; the slave side is the fill engine.
interface fb_rect_fill_if #(
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [7:0]         cmd_x;
  logic [6:0]         cmd_y;
  logic [7:0]         cmd_w;
  logic [6:0]         cmd_h;
  logic [COLOR_W-1:0] cmd_color;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_wdata;
  logic               fb_stall;
  logic               busy;
  logic               done;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_stall,
    input  cmd_ready, fb_we, fb_addr, fb_wdata, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_stall,
    output cmd_ready, fb_we, fb_addr, fb_wdata, busy, done
  );
endinterface

// File: rtl/fb_rect_fill.sv
// Rectangle fill for the 160x120 palette framebuffer: clips one command, then
// writes its pixels in raster order, one per unstalled cycle.
module fb_rect_fill #(
  parameter int FB_W    = 160,
  parameter int FB_H    = 120,
  parameter int ADDR_W  = 15,
  parameter int COLOR_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  fb_rect_fill_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

  localparam logic [8:0]      FB_W9  = 9'(FB_W);
  localparam logic [7:0]      FB_H8  = 8'(FB_H);
  localparam logic [ADDR_W:0] FB_WB  = (ADDR_W+1)'(FB_W);

  state_t             state;
  logic               cmd_ready;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_wdata;
  logic               busy;
  logic               done;

  logic [7:0]         x_q;
  logic [6:0]         y_q;
  logic [7:0]         w_q;
  logic [6:0]         h_q;
  logic [COLOR_W-1:0] color_q;
  logic [8:0]         xe_q;
  logic [7:0]         ye_q;
  logic [7:0]         cur_x;
  logic [6:0]         cur_y;
  logic [ADDR_W:0]    row_base;

  logic [8:0]         x_sum;
  logic [7:0]         y_sum;
  logic [8:0]         xe_calc;
  logic [7:0]         ye_calc;
  logic               empty;
  logic [ADDR_W:0]    base_calc;
  logic [ADDR_W:0]    next_base;
  logic               row_end;
  logic               last_row;

  assign x_sum   = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum   = {1'b0, y_q} + {1'b0, h_q};
  assign xe_calc = (x_sum > FB_W9) ? FB_W9 : x_sum;
  assign ye_calc = (y_sum > FB_H8) ? FB_H8 : y_sum;
  assign empty   = ({1'b0, x_q} >= FB_W9) || ({1'b0, y_q} >= FB_H8) ||
                   (w_q == 8'd0) || (h_q == 7'd0);

  // y*160 as y*128 + y*32; the shift amounts assume the 160-pixel row pitch.
  assign base_calc = (ADDR_W+1)'({y_q, 7'b0}) + (ADDR_W+1)'({y_q, 5'b0}) +
                     (ADDR_W+1)'(x_q);
  assign next_base = row_base + FB_WB;
  assign row_end   = (({1'b0, cur_x} + 9'd1) == xe_q);
  assign last_row  = (({1'b0, cur_y} + 8'd1) == ye_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_wdata  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      row_base  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            x_q       <= bus.cmd_x;
            y_q       <= bus.cmd_y;
            w_q       <= bus.cmd_w;
            h_q       <= bus.cmd_h;
            color_q   <= bus.cmd_color;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= CLIP;
          end
        end
        CLIP: begin
          xe_q <= xe_calc;
          ye_q <= ye_calc;
          if (empty) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cur_x    <= x_q;
            cur_y    <= y_q;
            row_base <= base_calc;
            fb_addr  <= base_calc[ADDR_W-1:0];
            fb_wdata <= color_q;
            fb_we    <= 1'b1;
            state    <= FILL;
          end
        end
        FILL: begin
          // Everything holds while the arbiter stalls the write port.
          if (!bus.fb_stall) begin
            if (row_end && last_row) begin
              fb_we <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else if (row_end) begin
              cur_x    <= x_q;
              cur_y    <= cur_y + 7'd1;
              row_base <= next_base;
              fb_addr  <= next_base[ADDR_W-1:0];
            end else begin
              cur_x   <= cur_x + 8'd1;
              fb_addr <= fb_addr + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.fb_we     = fb_we;
  assign bus.fb_addr   = fb_addr;
  assign bus.fb_wdata  = fb_wdata;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: each command's writes and done timing are
// compared against hand-computed addresses and cycle offsets from accept.
module tb_fb_rect_fill;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fb_rect_fill_if bus ();
  fb_rect_fill dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log and event counters, sampled on the falling edge.
  int unsigned wr_addr[$];
  int unsigned wr_data[$];
  int          wr_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cnt  = 0;
  int we_cnt   = 0;
  always @(negedge clk) begin
    if (bus.fb_we && !bus.fb_stall) begin
      wr_addr.push_back(32'(bus.fb_addr));
      wr_data.push_back(32'(bus.fb_wdata));
      wr_cyc.push_back(cyc);
    end
    if (bus.fb_we) we_cnt <= we_cnt + 1;
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.cmd_valid && bus.cmd_ready && rst) acc_cnt <= acc_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;
  int acc_cyc, wr0, done0, acc0, we0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int x, input int y, input int w, input int h,
                       input int c, input bit hold);
    wr0   = wr_addr.size();
    done0 = done_cnt;
    we0   = we_cnt;
    acc0  = acc_cnt;
    bus.cmd_x     = 8'(x);
    bus.cmd_y     = 7'(y);
    bus.cmd_w     = 8'(w);
    bus.cmd_h     = 7'(h);
    bus.cmd_color = 8'(c);
    bus.cmd_valid = 1'b1;
    chk("ready_at_issue", 32'(bus.cmd_ready), 1);
    acc_cyc = cyc;
    tick();
    if (!hold) bus.cmd_valid = 1'b0;
    $display("cmd x=%0d y=%0d w=%0d h=%0d color=0x%02h accepted at cycle %0d",
             x, y, w, h, c, acc_cyc);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == done0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done_cnt != done0), 1);
  endtask

  initial begin
    int bad;
    int unsigned small_exp[6];
    int unsigned clip_exp[4];
    small_exp = '{810, 811, 812, 970, 971, 972};
    clip_exp  = '{19038, 19039, 19198, 19199};

    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0; bus.cmd_y = '0; bus.cmd_w = '0; bus.cmd_h = '0;
    bus.cmd_color = '0;
    bus.fb_stall = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    chk("rst_we",    32'(bus.fb_we), 0);
    chk("rst_addr",  32'(bus.fb_addr), 0);
    chk("rst_wdata", 32'(bus.fb_wdata), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_done",  32'(bus.done), 0);
    rst = 1'b1;
    tick(); tick();

    // Full screen
    issue(0, 0, 160, 120, 8'h11, 1'b0);
    wait_done(20000);
    chk("full_count", 32'(wr_addr.size() - wr0), 19200);
    bad = 0;
    for (int i = 0; i < 19200 && wr0 + i < wr_addr.size(); i++)
      if (wr_addr[wr0+i] != 32'(i) || wr_data[wr0+i] != 32'h11) bad++;
    chk("full_seq_bad", 32'(bad), 0);
    chk("full_done_lat", 32'(done_cyc - acc_cyc), 19202);
    tick();
    chk("full_ready_after", 32'(bus.cmd_ready), 1);

    // Small rectangle
    issue(10, 5, 3, 2, 8'h2A, 1'b0);
    chk("small_busy", 32'(bus.busy), 1);
    wait_done(50);
    chk("small_count", 32'(wr_addr.size() - wr0), 6);
    for (int i = 0; i < 6 && wr0 + i < wr_addr.size(); i++) begin
      chk($sformatf("small_addr%0d", i), wr_addr[wr0+i], small_exp[i]);
      chk($sformatf("small_data%0d", i), wr_data[wr0+i], 32'h2A);
    end
    if (wr_addr.size() >= wr0 + 6) begin
      chk("small_first_lat", 32'(wr_cyc[wr0] - acc_cyc), 2);
      chk("small_done_after_last", 32'(done_cyc - wr_cyc[wr0+5]), 1);
    end
    tick();

    // Clipped to bottom-right corner
    issue(158, 118, 10, 10, 8'h5C, 1'b0);
    wait_done(50);
    chk("clip_count", 32'(wr_addr.size() - wr0), 4);
    for (int i = 0; i < 4 && wr0 + i < wr_addr.size(); i++)
      chk($sformatf("clip_addr%0d", i), wr_addr[wr0+i], clip_exp[i]);
    tick();

    // Fully off-screen
    issue(200, 0, 5, 5, 8'h77, 1'b0);
    wait_done(50);
    chk("offscr_writes", 32'(we_cnt - we0), 0);
    chk("offscr_done_lat", 32'(done_cyc - acc_cyc), 2);
    tick();

    // Zero width, cmd_valid held through busy
    issue(3, 3, 0, 7, 8'h44, 1'b1);
    wait_done(50);
    chk("zero_writes", 32'(we_cnt - we0), 0);
    chk("zero_done_lat", 32'(done_cyc - acc_cyc), 2);
    chk("zero_ready_next", 32'(bus.cmd_ready), 1);
    chk("zero_single_accept", 32'(acc_cnt - acc0), 1);
    bus.cmd_valid = 1'b0;
    tick();

    // Stall on the second write for three cycles
    issue(0, 0, 4, 1, 8'h33, 1'b0);
    tick();
    tick();
    bus.fb_stall = 1'b1;
    tick();
    chk("stall_we_a",   32'(bus.fb_we), 1);
    chk("stall_addr_a", 32'(bus.fb_addr), 1);
    tick();
    chk("stall_we_b",   32'(bus.fb_we), 1);
    chk("stall_addr_b", 32'(bus.fb_addr), 1);
    tick();
    bus.fb_stall = 1'b0;
    wait_done(50);
    chk("stall_count", 32'(wr_addr.size() - wr0), 4);
    for (int i = 0; i < 4 && wr0 + i < wr_addr.size(); i++)
      chk($sformatf("stall_addr%0d", i), wr_addr[wr0+i], 32'(i));
    chk("stall_done_lat", 32'(done_cyc - acc_cyc), 9);
    tick();

    // Asynchronous reset mid-fill
    issue(0, 0, 160, 120, 8'h66, 1'b0);
    for (int i = 0; i < 40; i++) tick();
    chk("mid_busy_before", 32'(bus.busy), 1);
    chk("mid_we_before", 32'(bus.fb_we), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_we_async",   32'(bus.fb_we), 0);
    chk("mid_busy_async", 32'(bus.busy), 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("mid_ready_after", 32'(bus.cmd_ready), 1);
    issue(0, 0, 1, 1, 8'h99, 1'b0);
    wait_done(50);
    chk("post_count", 32'(wr_addr.size() - wr0), 1);
    if (wr_addr.size() > wr0) begin
      chk("post_addr", wr_addr[wr0], 0);
      chk("post_data", wr_data[wr0], 32'h99);
    end
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fb_rect_fill.md
Name: fb_rect_fill

Overview:
Upstream drawing engine for the 160x120, 8-bit palette-index framebuffer that the VGA scan-out path reads. It accepts one rectangle-fill command at a time over a valid/ready handshake, clips the rectangle to the framebuffer, and issues one framebuffer write per cycle in raster order. The write port honours a stall input so a RAM arbiter shared with scan-out can back-pressure it.

Parameters:
FB_W, 160, framebuffer width in pixels
FB_H, 120, framebuffer height in pixels
ADDR_W, 15, framebuffer address width (FB_W*FB_H = 19200 entries)
COLOR_W, 8, palette index width

Ports:
clk  input  1  system clock; all logic is on its rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_x  input  8  left column, 0..255
cmd_y  input  7  top row, 0..127
cmd_w  input  8  width in pixels
cmd_h  input  7  height in pixels
cmd_color  input  COLOR_W  palette index to write
fb_we  output  1  write request
fb_addr  output  ADDR_W  write address, y*FB_W + x
fb_wdata  output  COLOR_W  write data
fb_stall  input  1  write port busy; the write is not taken this cycle
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse when the command completes

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-low.
- Reset values: state IDLE, cmd_ready=1, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, done=0.
- Reset asserted mid-fill: fb_we drops immediately (asynchronous) and the command is abandoned. After release, the block is in IDLE with cmd_ready=1.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
  - cmd_ready=1 only in IDLE. All cmd_* fields are registered at accept.
  - cmd_valid while not ready is ignored and has no side effects.
- States: IDLE -> CLIP -> FILL -> DONE -> IDLE, or IDLE -> CLIP -> DONE -> IDLE when the clipped rectangle is empty.
- CLIP (exactly one cycle after accept):
  - xe = min(x+w, FB_W) and ye = min(y+h, FB_H), computed at 9 and 8 bits with no wrap.
  - The rectangle is empty if x>=FB_W, y>=FB_H, w==0 or h==0. Empty goes to DONE with no writes.
  - Otherwise load cur_x=x, cur_y=y, row_base = y*FB_W + x. Compute row_base with shift-add (y*128 + y*32 + x); no generic multiplier.
- FILL:
  - fb_we=1 with fb_addr = row_base + (cur_x - x) and fb_wdata = the command colour.
  - First write is presented in the cycle after CLIP, i.e. two cycles after the accept edge.
  - A write is taken on an edge where fb_we=1 and fb_stall=0. Only then do cur_x and the address advance.
  - While fb_stall=1: fb_we, fb_addr and fb_wdata hold unchanged. Stall for any number of cycles is legal.
  - Row end (cur_x+1 == xe): cur_x returns to x, row_base += FB_W, cur_y++.
  - Last pixel taken (cur_x+1 == xe and cur_y+1 == ye): go to DONE. fb_we=0 from the next cycle.
  - Write order is strict raster: left to right, then top to bottom. No address is written twice and none outside the clip.
- DONE: done=1 for exactly one cycle, busy=1. Next cycle is IDLE with cmd_ready=1.
- Throughput: an unstalled, non-empty fill of N pixels occupies N FILL cycles. Accept to done is N+2 cycles; empty is 2 cycles.
- Arithmetic: the fb_addr maximum is 19199 and fits ADDR_W. Internal row_base is ADDR_W+1 bits so the final row_base += FB_W cannot overflow.

Test Plan:
- Full screen: x=0, y=0, w=160, h=120, colour 0x11, fb_stall=0 -> exactly 19200 writes at consecutive addresses 0..19199, all data 0x11. done is high 19202 cycles after accept.
- Small rectangle: x=10, y=5, w=3, h=2, colour 0x2A -> writes to addrs 810, 811, 812, 970, 971, 972 in that order, first write 2 cycles after accept. done is high in the cycle after the write to 972 is taken.
- Clipping: x=158, y=118, w=10, h=10 -> exactly 4 writes at 19038, 19039, 19198, 19199. A second command x=200, y=0, w=5, h=5 -> zero writes, done 2 cycles after accept.
- Zero size: w=0, h=7 -> no fb_we, done pulse 2 cycles after accept, cmd_ready back high the next cycle. cmd_valid held high during busy accepts nothing further.
- Stall: 4x1 fill at x=0, y=0 with fb_stall high for 3 cycles on the 2nd write -> fb_addr holds at 1 with fb_we=1 during the stall. Sequence 0, 1, 2, 3 with no duplicates. done arrives 3 cycles later than the unstalled case.
- Reset mid-fill: assert rst low during a 160x120 fill -> fb_we=0 without waiting for a clock edge, busy=0. After release, cmd_ready=1 and a new 1x1 command at (0,0) writes address 0 only.
